// File: rtl/feature_add_pkg.sv
// Shared types and defaults for the element-wise feature adder controller.
package feature_add_pkg;

  localparam int LANES              = 8;
  localparam int DEF_FEATURE_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_LEN_WIDTH      = 16;
  localparam int DEF_RD_LATENCY     = 2;
  localparam int DEF_FIFO_DEPTH     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/feature_sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
// Head data reads as zero while empty so downstream outputs stay quiet.
module feature_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/feature_add_ctrl.sv
// Adder sequencer: paired reads, adder controls, FIFO'd write-back; first write RD_LATENCY+3 after first read.
// Issue is credit-limited by inflight+FIFO occupancy so wr_ready backpressure never overflows. FEATURE_ADD_CTRL_PERF_EN adds a stall counter.
module feature_add_ctrl
  import feature_add_pkg::*;
#(
  parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int RD_LATENCY    = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                             system_clk,
  input  logic                             rst,
  input  logic                             task_start,
  input  logic [ADDR_WIDTH-1:0]            cfg_x1_base,
  input  logic [ADDR_WIDTH-1:0]            cfg_x2_base,
  input  logic [ADDR_WIDTH-1:0]            cfg_out_base,
  input  logic [LEN_WIDTH-1:0]             cfg_len,
  input  logic [2:0]                       cfg_relative_quant,
  input  logic                             cfg_quant_polar,
  input  logic                             cfg_over_flow,
  output logic                             task_busy,
  output logic                             task_done,
  output logic                             rd_en,
  output logic [ADDR_WIDTH-1:0]            rd_x1_addr,
  output logic [ADDR_WIDTH-1:0]            rd_x2_addr,
  output logic                             add_valid,
  output logic [2:0]                       add_relative_quant,
  output logic                             add_quant_polar,
  output logic                             add_over_flow,
  input  logic [FEATURE_WIDTH*LANES-1:0]   add_data,
  input  logic                             add_data_valid,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [FEATURE_WIDTH*LANES-1:0]   wr_data,
  input  logic                             wr_ready
`ifdef FEATURE_ADD_CTRL_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  localparam int DATA_W = FEATURE_WIDTH * LANES;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] x1_base;
  logic [ADDR_WIDTH-1:0] x2_base;
  logic [ADDR_WIDTH-1:0] out_base;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic [LEN_WIDTH-1:0]  wr_count;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credits_used;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     fifo_head;
  logic [RD_LATENCY-1:0] vld_pipe;

  logic start_acc;
  logic credit_ok;
  logic issue;
  logic last_issue;
  logic res_acc;
  logic wr_fire;

  assign start_acc    = (state == IDLE) && task_start;
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok    = credits_used < (CNT_W+1)'(FIFO_DEPTH);
  assign issue        = (state == RUN) && credit_ok;
  assign last_issue   = issue && (issue_cnt == len_q - LEN_WIDTH'(1));
  // Results landing while idle belong to no task and are discarded.
  assign res_acc      = add_data_valid && (state != IDLE);
  assign wr_fire      = !fifo_empty && wr_ready;

  assign task_busy  = (state != IDLE);
  assign task_done  = (state == DONE);
  assign rd_en      = issue;
  assign rd_x1_addr = x1_base + ADDR_WIDTH'(issue_cnt);
  assign rd_x2_addr = x2_base + ADDR_WIDTH'(issue_cnt);
  assign add_valid  = vld_pipe[RD_LATENCY-1];
  assign wr_en      = !fifo_empty;
  assign wr_addr    = out_base + ADDR_WIDTH'(wr_count);
  assign wr_data    = fifo_head;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (task_start) state_nxt = (cfg_len == '0) ? DONE : RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (wr_count == len_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      x1_base            <= '0;
      x2_base            <= '0;
      out_base           <= '0;
      len_q              <= '0;
      add_relative_quant <= '0;
      add_quant_polar    <= 1'b0;
      add_over_flow      <= 1'b0;
      issue_cnt          <= '0;
      wr_count           <= '0;
      inflight           <= '0;
    end else if (start_acc) begin
      x1_base            <= cfg_x1_base;
      x2_base            <= cfg_x2_base;
      out_base           <= cfg_out_base;
      len_q              <= cfg_len;
      add_relative_quant <= cfg_relative_quant;
      add_quant_polar    <= cfg_quant_polar;
      add_over_flow      <= cfg_over_flow;
      issue_cnt          <= '0;
      wr_count           <= '0;
      inflight           <= '0;
    end else begin
      if (issue)   issue_cnt <= issue_cnt + LEN_WIDTH'(1);
      if (wr_fire) wr_count  <= wr_count + LEN_WIDTH'(1);
      case ({issue, res_acc})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  feature_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (system_clk),
    .rst       (rst),
    .push      (res_acc),
    .push_data (add_data),
    .pop       (wr_fire),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef FEATURE_ADD_CTRL_PERF_EN
  logic stall;

  assign stall = ((state == RUN) && !credit_ok) || ((state == DRAIN) && wr_en && !wr_ready);

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst)                                    perf_stall_cycles <= '0;
    else if (start_acc)                         perf_stall_cycles <= '0;
    else if (stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`else
  // Stall accounting is compiled out in this build.
`endif

endmodule
